// File: rtl/mdu_sequencer_pkg.sv
// Shared definitions for the multiply/divide sequencer: MDUOp encodings,
// default latencies, FSM state and latched-request types, decode helpers.
// Latency: n/a (definitions only).  Backpressure: n/a.
package mdu_sequencer_pkg;

  // MDUOp encodings as driven by the E-stage control
  localparam logic [2:0] MDU_MULTU = 3'b000;
  localparam logic [2:0] MDU_MULT  = 3'b001;
  localparam logic [2:0] MDU_DIVU  = 3'b010;
  localparam logic [2:0] MDU_DIV   = 3'b011;

  // Default busy periods
  localparam int MDU_MULT_CYCLES_DEF = 5;
  localparam int MDU_DIV_CYCLES_DEF  = 10;

  // The down-counter is never narrower than this
  localparam int MDU_CNT_W_MIN = 4;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } mdu_state_e;

  // Decoded function; undefined MDUOp codes collapse onto FN_MULTU
  typedef enum logic [1:0] {
    FN_MULTU = 2'd0,
    FN_MULT  = 2'd1,
    FN_DIVU  = 2'd2,
    FN_DIV   = 2'd3
  } mdu_fn_e;

  // Operation captured when start is accepted
  typedef struct packed {
    mdu_fn_e     fn;
    logic [31:0] a;
    logic [31:0] b;
  } mdu_req_t;

  function automatic mdu_fn_e mdu_decode(input logic [2:0] op);
    mdu_fn_e fn;
    case (op)
      MDU_MULT: fn = FN_MULT;
      MDU_DIVU: fn = FN_DIVU;
      MDU_DIV:  fn = FN_DIV;
      default:  fn = FN_MULTU;
    endcase
    return fn;
  endfunction

  function automatic logic mdu_is_div(input mdu_fn_e fn);
    return (fn == FN_DIVU) || (fn == FN_DIV);
  endfunction

  // Counter width: at least MDU_CNT_W_MIN, wide enough to hold the longer latency
  function automatic int mdu_cnt_width(input int mult_cycles, input int div_cycles);
    int max_c;
    int w;
    max_c = (mult_cycles > div_cycles) ? mult_cycles : div_cycles;
    w = MDU_CNT_W_MIN;
    while ((1 << w) <= max_c) w++;
    return w;
  endfunction

endpackage

// File: rtl/mdu_sequencer_arith.sv
// mdu_arith: combinational mult/div datapath producing {hi,lo} from a latched request.
// Latency: purely combinational, no state.  Backpressure: none.
// Ports: fn_i/a_i/b_i latched op and operands; hi_o/lo_o result; div_zero_o divide by zero.
module mdu_arith
  import mdu_sequencer_pkg::*;
(
  input  mdu_fn_e     fn_i,
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  output logic [31:0] hi_o,
  output logic [31:0] lo_o,
  output logic        div_zero_o
);

  logic        is_div;
  logic        signed_op;
  logic        a_neg;
  logic        b_neg;
  logic        b_zero;
  logic [63:0] a_ext;
  logic [63:0] b_ext;
  logic [63:0] prod;
  logic [31:0] a_mag;
  logic [31:0] b_mag;
  logic [31:0] b_safe;
  logic [31:0] q_mag;
  logic [31:0] r_mag;
  logic [31:0] quot;
  logic [31:0] rem;

  always_comb begin
    is_div    = mdu_is_div(fn_i);
    signed_op = (fn_i == FN_MULT) || (fn_i == FN_DIV);
    a_neg     = signed_op & a_i[31];
    b_neg     = signed_op & b_i[31];
    b_zero    = (b_i == 32'd0);

    // One 64x64 multiplier serves both flavours: the low 64 bits of the
    // product of sign- or zero-extended operands is the exact result.
    a_ext = {{32{a_neg}}, a_i};
    b_ext = {{32{b_neg}}, b_i};
    prod  = a_ext * b_ext;

    // Signed divide runs on magnitudes. 0x80000000 has magnitude 0x80000000
    // as an unsigned value, so 0x80000000 / -1 yields 0x80000000 naturally.
    a_mag  = a_neg ? (32'd0 - a_i) : a_i;
    b_mag  = b_neg ? (32'd0 - b_i) : b_i;
    // Keep the divider away from a zero divisor; the result is discarded anyway
    b_safe = b_zero ? 32'd1 : b_mag;
    q_mag  = a_mag / b_safe;
    r_mag  = a_mag % b_safe;
    // Quotient truncates toward zero; remainder follows the dividend's sign
    quot   = (a_neg ^ b_neg) ? (32'd0 - q_mag) : q_mag;
    rem    = a_neg ? (32'd0 - r_mag) : r_mag;

    if (is_div) begin
      hi_o = rem;
      lo_o = quot;
    end else begin
      hi_o = prod[63:32];
      lo_o = prod[31:0];
    end
    div_zero_o = is_div & b_zero;
  end

endmodule

// File: rtl/mdu_sequencer.sv
// mdu_sequencer: E-stage multi-cycle mult/div sequencer owning HI/LO, with mthi/mtlo.
// Latency: MULT_CYCLES / DIV_CYCLES busy cycles after start; result in HI/LO as busy falls.
// Backpressure: stallMD = MDD & (start | busy) holds Decode; start/moves in RUN are ignored.
// Ports: clk, reset (async active-low); start/MDUOp/A/B issue an op; HIWrite/LOWrite
//        move A into HI/LO; MDD flags an MD-class D-stage instruction; busy, stallMD, HI, LO out.
module mdu_sequencer
  import mdu_sequencer_pkg::*;
#(
  parameter int MULT_CYCLES = MDU_MULT_CYCLES_DEF,
  parameter int DIV_CYCLES  = MDU_DIV_CYCLES_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  MDUOp,
  input  logic        HIWrite,
  input  logic        LOWrite,
  input  logic [31:0] A,
  input  logic [31:0] B,
  input  logic        MDD,
  output logic        busy,
  output logic        stallMD,
  output logic [31:0] HI,
  output logic [31:0] LO
);

  localparam int CNT_W = mdu_cnt_width(MULT_CYCLES, DIV_CYCLES);
  localparam logic [CNT_W-1:0] MULT_LOAD = CNT_W'(MULT_CYCLES);
  localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(DIV_CYCLES);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  mdu_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  mdu_req_t         req_q, req_d;
  logic [31:0]      hi_q, hi_d;
  logic [31:0]      lo_q, lo_d;

  mdu_fn_e     start_fn;
  logic        finish;
  logic [31:0] res_hi;
  logic [31:0] res_lo;
  logic        res_div_zero;

  assign start_fn = mdu_decode(MDUOp);
  // Last busy cycle: the result is committed at the edge that ends it
  assign finish   = (state_q == ST_RUN) && (cnt_q == CNT_ONE);

  mdu_arith u_arith (
    .fn_i       (req_q.fn),
    .a_i        (req_q.a),
    .b_i        (req_q.b),
    .hi_o       (res_hi),
    .lo_o       (res_lo),
    .div_zero_o (res_div_zero)
  );

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      req_q   <= '0;
      hi_q    <= 32'd0;
      lo_q    <= 32'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      req_q   <= req_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

  // Next-state: sequencing, counter and operand capture
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    req_d   = req_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_RUN;
          cnt_d   = mdu_is_div(start_fn) ? DIV_LOAD : MULT_LOAD;
          req_d   = '{fn: start_fn, a: A, b: B};
        end
      end
      ST_RUN: begin
        cnt_d = cnt_q - CNT_ONE;
        if (cnt_q == CNT_ONE) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Outputs and HI/LO update
  always_comb begin
    busy    = (state_q == ST_RUN);
    stallMD = MDD & (start | busy);
    hi_d    = hi_q;
    lo_d    = lo_q;
    // Moves only land in IDLE, and a simultaneous start wins over them
    if ((state_q == ST_IDLE) && !start) begin
      if (HIWrite) hi_d = A;
      if (LOWrite) lo_d = A;
    end
    // A zero divisor still burns the busy period but leaves HI/LO alone
    if (finish && !res_div_zero) begin
      hi_d = res_hi;
      lo_d = res_lo;
    end
  end

  assign HI = hi_q;
  assign LO = lo_q;

endmodule

// File: tb/tb_mdu_sequencer.sv
// Self-checking bench for mdu_sequencer: directed scenarios with literal results plus
// randomized ops, all compared every cycle against a time-based behavioural model.
// Latency/backpressure: bench only; never issues start or moves while busy.
module tb_mdu_sequencer;

  localparam int MULT_N = 5;
  localparam int DIV_N  = 10;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [2:0]  MDUOp;
  logic        HIWrite;
  logic        LOWrite;
  logic [31:0] A;
  logic [31:0] B;
  logic        MDD;
  logic        busy;
  logic        stallMD;
  logic [31:0] HI;
  logic [31:0] LO;

  always #5 clk = ~clk;

  mdu_sequencer #(
    .MULT_CYCLES (MULT_N),
    .DIV_CYCLES  (DIV_N)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .start   (start),
    .MDUOp   (MDUOp),
    .HIWrite (HIWrite),
    .LOWrite (LOWrite),
    .A       (A),
    .B       (B),
    .MDD     (MDD),
    .busy    (busy),
    .stallMD (stallMD),
    .HI      (HI),
    .LO      (LO)
  );

  int n_checks = 0;
  int n_pass   = 0;
  bit chk_en   = 1'b0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", nm, act, exp, $time);
  endtask

  // ---------------- behavioural model ----------------
  // Time-based: an op started in cycle c is busy until cycle c+N and its
  // result becomes visible in cycle c+N+1 (m_done).
  int          cyc    = 0;
  int          m_done = 0;
  logic [31:0] m_hi   = 32'd0;
  logic [31:0] m_lo   = 32'd0;
  logic [31:0] p_hi   = 32'd0;
  logic [31:0] p_lo   = 32'd0;
  bit          p_wr   = 1'b0;

  function automatic int lat_of(input logic [2:0] op);
    return (op == 3'd2 || op == 3'd3) ? DIV_N : MULT_N;
  endfunction

  function automatic logic [63:0] ref_result(input logic [2:0] op, input logic [31:0] a,
                                             input logic [31:0] b, output bit wr);
    longint          sa, sb, sq, sr;
    longint unsigned ua, ub, up;
    logic [63:0]     r;
    wr = 1'b1;
    r  = 64'd0;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'd0, a};
    ub = {32'd0, b};
    case (op)
      3'd1: r = sa * sb;
      3'd2: begin
        if (b == 32'd0) wr = 1'b0;
        else r = {a % b, a / b};
      end
      3'd3: begin
        if (b == 32'd0) wr = 1'b0;
        else begin
          sq = sa / sb;
          sr = sa % sb;
          r  = {sr[31:0], sq[31:0]};
        end
      end
      default: begin
        up = ua * ub;
        r  = up;
      end
    endcase
    return r;
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    forever begin
      @(posedge clk or negedge reset);
      if (!reset) begin
        m_hi   = 32'd0;
        m_lo   = 32'd0;
        m_done = 0;
        p_wr   = 1'b0;
      end else begin
        if (cyc >= m_done) begin
          if (start) begin
            {p_hi, p_lo} = ref_result(MDUOp, A, B, p_wr);
            m_done = cyc + lat_of(MDUOp) + 1;
          end else begin
            if (HIWrite) m_hi = A;
            if (LOWrite) m_lo = A;
          end
        end
        if ((cyc + 1 == m_done) && p_wr) begin
          m_hi = p_hi;
          m_lo = p_lo;
        end
      end
    end
  end

  // Per-cycle comparison against the model
  always @(negedge clk) begin
    if (chk_en) begin
      check("busy", {31'd0, busy}, {31'd0, cyc < m_done});
      check("stallMD", {31'd0, stallMD}, {31'd0, MDD & (start | (cyc < m_done))});
      check("HI", HI, m_hi);
      check("LO", LO, m_lo);
      check("no_issue_in_run", {31'd0, busy & (start | HIWrite | LOWrite)}, 32'd0);
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic launch(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        input bit mdd);
    MDUOp = op;
    A     = a;
    B     = b;
    MDD   = mdd;
    start = 1'b1;
    #1;
    if (mdd) check("stall_on_start", {31'd0, stallMD}, 32'd1);
    step();
    start   = 1'b0;
    HIWrite = 1'b0;
    LOWrite = 1'b0;
    // Scramble the buses: the DUT must work from its latched copy
    A       = $urandom;
    B       = $urandom;
    MDUOp   = 3'($urandom_range(0, 7));
  endtask

  task automatic wait_done(output int nb);
    nb = 0;
    while (busy === 1'b1 && nb < 40) begin
      nb++;
      step();
    end
  endtask

  task automatic run_op(input string nm, input logic [2:0] op, input logic [31:0] a,
                        input logic [31:0] b, input bit mdd, input int exp_n);
    int nb;
    launch(op, a, b, mdd);
    wait_done(nb);
    check({nm, "_busy_cycles"}, nb, exp_n);
    if (mdd) check({nm, "_stall_released"}, {31'd0, stallMD}, 32'd0);
    MDD = 1'b0;
  endtask

  task automatic move(input bit hiw, input bit low, input logic [31:0] val);
    HIWrite = hiw;
    LOWrite = low;
    A       = val;
    step();
    HIWrite = 1'b0;
    LOWrite = 1'b0;
  endtask

  // ---------------- test sequence ----------------
  initial begin
    int nb;
    reset   = 1'b1;
    start   = 1'b0;
    MDUOp   = 3'd0;
    HIWrite = 1'b0;
    LOWrite = 1'b0;
    A       = 32'd0;
    B       = 32'd0;
    MDD     = 1'b0;
    #1 reset = 1'b0;
    chk_en = 1'b1;
    #2;
    check("reset_busy", {31'd0, busy}, 32'd0);
    check("reset_stall", {31'd0, stallMD}, 32'd0);
    check("reset_HI", HI, 32'd0);
    check("reset_LO", LO, 32'd0);
    step();
    step();
    reset = 1'b1;
    step();

    // mult -2 * 3
    run_op("mult", 3'd1, 32'hFFFF_FFFE, 32'd3, 1'b0, MULT_N);
    check("mult_HI", HI, 32'hFFFF_FFFF);
    check("mult_LO", LO, 32'hFFFF_FFFA);

    // div -7 / 2 and divu 7 / 2
    run_op("div", 3'd3, 32'hFFFF_FFF9, 32'd2, 1'b0, DIV_N);
    check("div_LO", LO, 32'hFFFF_FFFD);
    check("div_HI", HI, 32'hFFFF_FFFF);
    run_op("divu", 3'd2, 32'd7, 32'd2, 1'b0, DIV_N);
    check("divu_LO", LO, 32'd3);
    check("divu_HI", HI, 32'd1);

    // undefined code behaves as multu
    run_op("op5_multu", 3'd5, 32'hFFFF_FFFF, 32'd2, 1'b0, MULT_N);
    check("op5_HI", HI, 32'd1);
    check("op5_LO", LO, 32'hFFFF_FFFE);

    // stall across a multu, then moves
    run_op("stall_multu", 3'd0, 32'd3, 32'd4, 1'b1, MULT_N);
    move(1'b1, 1'b0, 32'h1234);
    check("mthi_HI", HI, 32'h1234);
    LOWrite = 1'b1;
    run_op("start_beats_mtlo", 3'd1, 32'd9, 32'd11, 1'b0, MULT_N);
    check("start_beats_mtlo_LO", LO, 32'd99);
    check("start_beats_mtlo_HI", HI, 32'd0);

    // divide by zero leaves HI/LO untouched
    move(1'b1, 1'b0, 32'd5);
    move(1'b0, 1'b1, 32'd6);
    run_op("divzero", 3'd2, 32'd1234, 32'd0, 1'b0, DIV_N);
    check("divzero_HI", HI, 32'd5);
    check("divzero_LO", LO, 32'd6);

    // reset during the third busy cycle of a div
    launch(3'd3, 32'hFFFF_FFF9, 32'd2, 1'b1);
    step();
    step();
    reset = 1'b0;
    #1;
    check("midreset_busy", {31'd0, busy}, 32'd0);
    check("midreset_HI", HI, 32'd0);
    check("midreset_LO", LO, 32'd0);
    check("midreset_stall", {31'd0, stallMD}, 32'd0);
    step();
    reset = 1'b1;
    MDD   = 1'b0;
    step();
    run_op("post_reset_mult", 3'd1, 32'd5, 32'd6, 1'b0, MULT_N);
    check("post_reset_LO", LO, 32'd30);
    check("post_reset_HI", HI, 32'd0);

    // back-to-back: div issued in the cycle the mult's busy falls
    launch(3'd1, 32'd100, 32'd7, 1'b0);
    wait_done(nb);
    check("b2b_mult_busy_cycles", nb, MULT_N);
    check("b2b_mult_LO", LO, 32'd700);
    launch(3'd3, 32'hFFFF_FF9C, 32'd7, 1'b0);
    check("b2b_no_bubble", {31'd0, busy}, 32'd1);
    wait_done(nb);
    check("b2b_div_busy_cycles", nb - 1, DIV_N - 1);
    check("b2b_div_LO", LO, 32'hFFFF_FFF2);
    check("b2b_div_HI", HI, 32'hFFFF_FFFE);

    // signed overflow case
    run_op("div_ovf", 3'd3, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, DIV_N);
    check("div_ovf_LO", LO, 32'h8000_0000);
    check("div_ovf_HI", HI, 32'd0);

    // randomized ops, gaps and moves
    for (int i = 0; i < 250; i++) begin
      logic [2:0]  op;
      logic [31:0] a;
      logic [31:0] b;
      int          gap;
      gap = $urandom_range(0, 3);
      for (int g = 0; g < gap; g++) begin
        HIWrite = ($urandom_range(0, 3) == 0);
        LOWrite = ($urandom_range(0, 3) == 0);
        A       = $urandom;
        MDD     = $urandom_range(0, 1);
        step();
      end
      HIWrite = 1'b0;
      LOWrite = ($urandom_range(0, 7) == 0);
      op = 3'($urandom_range(0, 7));
      a  = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 20)) : $urandom;
      case ($urandom_range(0, 7))
        0:       b = 32'd0;
        1:       b = 32'hFFFF_FFFF;
        2:       b = 32'($urandom_range(1, 9));
        default: b = $urandom;
      endcase
      run_op("rand", op, a, b, 1'($urandom_range(0, 1)), lat_of(op));
    end

    step();
    step();
    chk_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
